logicnet_lut_layer_pipe: RTL and testbench
==========================================

// Module: logicnet_lut_layer_pipe
// PURPOSE
//  Array of N_NEURONS runtime-programmable truth-table neurons, each mapping IN_BITS -> OUT_BITS.
//  Successor to the fixed, combinational per-neuron ROMs: the tables are loadable, the lookup is registered,
//  and valid/ready flow control is added. Sits between quantised-feature producer and next LogicNet layer.
// PARAMETERS
//  IN_BITS    6  fan-in bits per neuron (table depth 2**IN_BITS)
//  OUT_BITS   2  output bits per neuron
//  N_NEURONS  4  neurons (channels) in the layer; SEL_W = max(1,$clog2(N_NEURONS))
// PORTS
//  clk        in   1                    clock, rising edge
//  rst_n      in   1                    asynchronous active-low reset
//  cfg_start  in   1                    request table (re)load; honoured in RUN
//  cfg_done   in   1                    end table load; honoured in CFG
//  cfg_we     in   1                    table write strobe; honoured in CFG only
//  cfg_sel    in   SEL_W                target neuron; values >= N_NEURONS ignored
//  cfg_addr   in   IN_BITS              table entry index
//  cfg_data   in   OUT_BITS             table entry value
//  state_o    out  2                    00 CFG, 01 RUN, 10 DRAIN
//  in_valid   in   1                    input vector valid
//  in_ready   out  1                    input accepted when in_valid&in_ready
//  in_data    in   N_NEURONS*IN_BITS    neuron n input = in_data[n*IN_BITS +: IN_BITS]
//  out_valid  out  1                    result valid
//  out_ready  in   1                    downstream accepts
//  out_data   out  N_NEURONS*OUT_BITS   neuron n output = out_data[n*OUT_BITS +: OUT_BITS]
//  parity_err out  1                    sticky table-parity error (LUT_PARITY_EN only; else 0)
// BEHAVIOUR
//  Reset: state CFG, all table entries 0, out_valid 0, out_data 0, parity_err 0; in_ready 0.
//  FSM: CFG --cfg_done--> RUN; RUN --cfg_start--> DRAIN; DRAIN --(out_valid==0)--> CFG (same cycle if already 0).
//   cfg_start in CFG/DRAIN ignored; cfg_done outside CFG ignored; cfg_we outside CFG ignored.
//   cfg_we and cfg_done same cycle in CFG: write lands, then RUN next cycle.
//  Config write: entry [cfg_sel][cfg_addr] <= cfg_data on clock edge; visible to lookups from next cycle.
//  Datapath: single register stage, latency 1 cycle. in_ready = (state==RUN) & (~out_valid | out_ready).
//   Accept: out_data <= per-neuron table[n][in_data slice], out_valid <= 1.
//   out_valid & out_ready & no accept: out_valid <= 0, out_data holds last value.
//   Accept and drain same cycle: new result replaces old, out_valid stays 1 (full throughput, 1 vector/cycle).
//   out_valid & ~out_ready: out_data/out_valid stable (no change while stalled).
//  DRAIN: in_ready 0, held result still delivered normally; table not writable until CFG reached.
//  cfg_start and accept in same RUN cycle: accept completes; state DRAIN next cycle.
//  Reset mid-operation (any state): immediate return to reset values, in-flight result discarded.
// CONFIGURATION
//  LUT_PARITY_EN defined: each entry stores an even-parity bit computed on write; every accepted lookup
//   rechecks all N_NEURONS read entries; mismatch sets parity_err (sticky until rst_n). out_data unaffected.
//  LUT_PARITY_EN undefined: no parity storage or check; parity_err tied 0.
// STRUCTURE
//  Package logicnet_lut_pkg: state enum (CFG/RUN/DRAIN encodings above), state width localparam.
//  Sub-module logicnet_lut_bank: one neuron's table (write port + async read), instanced N_NEURONS times.
// TESTING
//  Reset, load neuron0 entry 0x0C=2'b11, cfg_done; send in_data slice0=0x0C -> 1 cycle later out_valid, slice0=2'b11.
//  Unwritten entry lookup (slice0=0x3F) after reset -> slice0=2'b00.
//  Stream 8 vectors, out_ready=1 -> in_ready constant 1, 8 results on 8 consecutive cycles, in order.
//  out_ready=0 for 3 cycles with out_valid=1 -> in_ready 0, out_data stable; release -> next vector accepted.
//  cfg_start while out_valid & ~out_ready -> state DRAIN, in_ready 0; out_ready=1 -> CFG next cycle;
//   cfg_we in RUN/DRAIN leaves table unchanged (verified by re-lookup after cfg_done).
//  LUT_PARITY_EN: force bit flip in bank entry, look it up -> parity_err 1 next cycle, stays 1 until rst_n.

Source files
------------

// File: rtl/logicnet_lut_pkg.sv
// rtl/logicnet_lut_pkg.sv - shared types and helpers for the LogicNet LUT layer
// Purpose: FSM state encoding and the table-parity helper used by bank and top.
// Ports: none (package).
package logicnet_lut_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_CFG   = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    // Select width never collapses to zero, even for a single-neuron layer.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Even parity over a table entry: XOR of all data bits.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/logicnet_lut_bank.sv
// rtl/logicnet_lut_bank.sv - one neuron's programmable truth table
// Purpose: 2**IN_BITS x OUT_BITS table with a synchronous write port and an
//          asynchronous read port. With LUT_PARITY_EN defined, each entry also
//          keeps an even-parity bit and the read port reports a parity mismatch.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears every entry)
//   i_we         write strobe
//   i_waddr      write entry index
//   i_wdata      write entry value
//   i_raddr      read entry index
//   o_rdata      read entry value (combinational)
//   o_par_err    read entry fails parity (LUT_PARITY_EN only)
module logicnet_lut_bank
    import logicnet_lut_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [IN_BITS-1:0]  i_waddr,
    input  logic [OUT_BITS-1:0] i_wdata,
    input  logic [IN_BITS-1:0]  i_raddr,
`ifdef LUT_PARITY_EN
    output logic                o_par_err,
`endif
    output logic [OUT_BITS-1:0] o_rdata
);

    localparam int DEPTH = 1 << IN_BITS;

    logic [OUT_BITS-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

`ifdef LUT_PARITY_EN
    logic r_par [DEPTH];

    // All-zero reset entries have even parity 0, so the cleared table is consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_par[i] <= 1'b0;
            end
        end else if (i_we) begin
            r_par[i_waddr] <= even_parity(32'(i_wdata));
        end
    end

    assign o_par_err = even_parity(32'(r_mem[i_raddr])) ^ r_par[i_raddr];
`endif

endmodule

// File: rtl/logicnet_lut_layer_pipe.sv
// rtl/logicnet_lut_layer_pipe.sv - registered layer of programmable LUT neurons
// Purpose: N_NEURONS loadable truth tables (IN_BITS -> OUT_BITS each) behind a
//          one-stage valid/ready pipeline, with a CFG/RUN/DRAIN load FSM.
//          Optional macro LUT_PARITY_EN adds per-entry parity and a sticky error flag.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_start/cfg_done         request reload (RUN) / finish load (CFG)
//   cfg_we/cfg_sel/cfg_addr/cfg_data  table write, honoured in CFG only
//   state_o                    00 CFG, 01 RUN, 10 DRAIN
//   in_valid/in_ready/in_data  input vector handshake, IN_BITS per neuron
//   out_valid/out_ready/out_data  result handshake, OUT_BITS per neuron
//   parity_err                 sticky table-parity error (0 without LUT_PARITY_EN)
module logicnet_lut_layer_pipe
    import logicnet_lut_pkg::*;
#(
    parameter  int IN_BITS   = 6,
    parameter  int OUT_BITS  = 2,
    parameter  int N_NEURONS = 4,
    localparam int SEL_W     = sel_width(N_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_start,
    input  logic                          cfg_done,
    input  logic                          cfg_we,
    input  logic [SEL_W-1:0]              cfg_sel,
    input  logic [IN_BITS-1:0]            cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_data,
    output logic [STATE_W-1:0]            state_o,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    output logic                          parity_err
);

    state_e                        r_state;
    state_e                        w_next_state;
    logic                          r_out_valid;
    logic [N_NEURONS*OUT_BITS-1:0] r_out_data;
    logic [N_NEURONS*OUT_BITS-1:0] w_lut;
    logic                          w_cfg_wr;
    logic                          w_accept;

    assign w_cfg_wr = (r_state == ST_CFG) & cfg_we;
    assign in_ready = (r_state == ST_RUN) & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

`ifdef LUT_PARITY_EN
    logic [N_NEURONS-1:0] w_par_err;
`endif

    // Out-of-range cfg_sel values match no bank, so the write is dropped.
    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        logicnet_lut_bank #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_we      (w_cfg_wr & (cfg_sel == SEL_W'(n))),
            .i_waddr   (cfg_addr),
            .i_wdata   (cfg_data),
            .i_raddr   (in_data[n*IN_BITS +: IN_BITS]),
`ifdef LUT_PARITY_EN
            .o_par_err (w_par_err[n]),
`endif
            .o_rdata   (w_lut[n*OUT_BITS +: OUT_BITS])
        );
    end

    // DRAIN leaves as soon as the output register is, or is about to be, empty;
    // no accept can happen in DRAIN, so a taken handshake means empty next cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CFG:   if (cfg_done)                    w_next_state = ST_RUN;
            ST_RUN:   if (cfg_start)                   w_next_state = ST_DRAIN;
            ST_DRAIN: if (~r_out_valid | out_ready)    w_next_state = ST_CFG;
            default:                                   w_next_state = ST_CFG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CFG;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_lut;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef LUT_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (w_accept && (|w_par_err)) begin
            r_parity_err <= 1'b1;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign state_o   = r_state;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_logicnet_lut_layer_pipe.sv
// tb/tb_logicnet_lut_layer_pipe.sv - scoreboard bench for logicnet_lut_layer_pipe
module tb_logicnet_lut_layer_pipe;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, cfg_done, cfg_we;
    logic [1:0]  cfg_sel;
    logic [5:0]  cfg_addr;
    logic [1:0]  cfg_data;
    logic [1:0]  state_o;
    logic        in_valid, in_ready;
    logic [23:0] in_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic        parity_err;

    logic [1:0]  mdl [N][64];
    logic [7:0]  sbq [$];
    logic [7:0]  mon_exp;
    int          n_vec = 0;
    int          n_err = 0;
    logic        fr;

    logicnet_lut_layer_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_done   (cfg_done),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .state_o    (state_o),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_of(input logic [23:0] d);
        logic [7:0] e;
        for (int n = 0; n < N; n++) e[n*2 +: 2] = mdl[n][d[n*6 +: 6]];
        return e;
    endfunction

    // Monitor: a transfer happens at the next rising edge whenever valid&ready now.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                mon_exp = sbq.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [5:0] addr,
                             input logic [1:0] data, input bit done, input bit upd);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data; cfg_done = done;
        tick();
        cfg_we = 1'b0; cfg_done = 1'b0;
        if (upd) mdl[sel][addr] = data;
    endtask

    task automatic pulse_done();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
    endtask

    // Presents d until accepted (bounded); pushes the expected result at acceptance.
    task automatic send(input logic [23:0] d, output logic first_ready);
        bit ok;
        ok = 1'b0;
        first_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) first_ready = in_ready;
            if (in_ready) begin
                ok = 1'b1;
                sbq.push_back(exp_of(d));
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            tick();
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
    endtask

    initial begin
        for (int n = 0; n < N; n++)
            for (int a = 0; a < 64; a++) mdl[n][a] = 2'b00;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_done = 1'b0; cfg_we = 1'b0;
        cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_parity_err", 32'(parity_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // Table load; the last write shares its cycle with cfg_done.
        cfg_write(2'd0, 6'h0C, 2'b11, 1'b0, 1'b1);
        for (int n = 0; n < N; n++)
            for (int k = 0; k < 8; k++)
                cfg_write(2'(n), 6'(k + 1), 2'((k + n) & 3), 1'b0, 1'b1);
        cfg_write(2'd3, 6'h3F, 2'b11, 1'b1, 1'b1);
        chk("run_state", 32'(state_o), 32'h1);
        chk("run_in_ready", 32'(in_ready), 32'h1);

        // Single lookups with one-cycle latency.
        send({18'h0, 6'h0C}, fr);
        in_valid = 1'b0;
        chk("latency_out_valid", 32'(out_valid), 32'h1);
        chk("latency_out_data", 32'(out_data), 32'h03);
        send({6'h3F, 12'h0, 6'h3F}, fr);
        in_valid = 1'b0;
        chk("unwritten_out_data", 32'(out_data), 32'hC0);

        // Back-to-back stream: accepted on every cycle.
        for (int k = 0; k < 8; k++) begin
            send({4{6'(k + 1)}}, fr);
            chk("stream_in_ready", 32'(fr), 32'h1);
        end
        in_valid = 1'b0;
        tick();

        // Stall: result held, input blocked, then released.
        out_ready = 1'b0;
        send({4{6'd2}}, fr);
        in_valid = 1'b1;
        in_data  = {4{6'd3}};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_out_valid", 32'(out_valid), 32'h1);
            chk("stall_out_data", 32'(out_data), 32'h39);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send({4{6'd3}}, fr);
        in_valid = 1'b0;
        chk("release_out_data", 32'(out_data), 32'h4E);
        tick();

        // Reload request while stalled; writes outside CFG must be dropped.
        out_ready = 1'b0;
        send({4{6'd1}}, fr);
        in_valid = 1'b0;
        cfg_start = 1'b1;
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 6'h0C; cfg_data = 2'b00;
        tick();
        cfg_start = 1'b0;
        cfg_addr = 6'h01; cfg_data = 2'b11;
        chk("drain_state", 32'(state_o), 32'h2);
        chk("drain_in_ready", 32'(in_ready), 32'h0);
        chk("drain_out_valid", 32'(out_valid), 32'h1);
        tick();
        cfg_we = 1'b0;
        chk("drain_hold_state", 32'(state_o), 32'h2);
        out_ready = 1'b1;
        tick();
        chk("cfg_state", 32'(state_o), 32'h0);
        chk("cfg_out_valid", 32'(out_valid), 32'h0);
        pulse_done();
        chk("rerun_state", 32'(state_o), 32'h1);
        send({6'h01, 6'h01, 6'h01, 6'h0C}, fr);
        in_valid = 1'b0;
        chk("ignored_we_a", 32'(out_data), 32'hE7);
        send({18'h0, 6'h01}, fr);
        in_valid = 1'b0;
        chk("ignored_we_b", 32'(out_data), 32'h00);
        tick();

        // Asynchronous reset with a result in flight.
        out_ready = 1'b0;
        send({4{6'd2}}, fr);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_data", 32'(out_data), 32'h0);
        chk("midrst_state", 32'(state_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < N; n++)
            for (int a = 0; a < 64; a++) mdl[n][a] = 2'b00;

`ifdef LUT_PARITY_EN
        cfg_write(2'd0, 6'h05, 2'b10, 1'b0, 1'b1);
        dut.g_neuron[0].u_bank.r_mem[5] = 2'b11;
        mdl[0][5] = 2'b11;
        pulse_done();
        send({18'h0, 6'h05}, fr);
        in_valid = 1'b0;
        chk("parity_corrupt_data", 32'(out_data), 32'h03);
        chk("parity_err_set", 32'(parity_err), 32'h1);
        send({18'h0, 6'h0C}, fr);
        in_valid = 1'b0;
        tick();
        chk("parity_err_sticky", 32'(parity_err), 32'h1);
`else
        pulse_done();
        chk("parity_err_tied", 32'(parity_err), 32'h0);
`endif
        send({18'h0, 6'h0C}, fr);
        in_valid = 1'b0;
        chk("post_rst_cleared", 32'(out_data), 32'h00);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
